// File: rtl/decodificador_notas.sv
// ============================================================================
// Module   : decodificador_notas
// Purpose  : Glitch-filtered 7-segment grade decoder with status tallies.
//            Optional macro GRADE_CONSISTENCY_CHECK_EN enables digit/status check.
// Revision : 1.0
// ============================================================================
`default_nettype none

module decodificador_notas #(
    parameter int STABLE_CYCLES = 4,
    parameter int NBITS_CNT     = 8
) (
    input  logic                 clk_2,
    input  logic                 reset,
    input  logic [6:0]           seg_in,
    output logic                 dec_valid,
    output logic [1:0]           dec_kind,
    output logic [3:0]           dec_digit,
    output logic [1:0]           dec_status,
    output logic [NBITS_CNT-1:0] cnt_aprov,
    output logic [NBITS_CNT-1:0] cnt_recup,
    output logic [NBITS_CNT-1:0] cnt_reprov,
    output logic                 err_invalid,
    output logic                 mismatch
);

    localparam logic [1:0] c_KIND_BLANK   = 2'd0;
    localparam logic [1:0] c_KIND_DIGIT   = 2'd1;
    localparam logic [1:0] c_KIND_STATUS  = 2'd2;
    localparam logic [1:0] c_KIND_INVALID = 2'd3;

    localparam logic [1:0] c_ST_NONE   = 2'd0;
    localparam logic [1:0] c_ST_APROV  = 2'd1;
    localparam logic [1:0] c_ST_RECUP  = 2'd2;
    localparam logic [1:0] c_ST_REPROV = 2'd3;

    localparam logic [7:0] c_ACCEPT_CNT = 8'(STABLE_CYCLES - 2);

    typedef enum logic [0:0] {
        SETTLE = 1'b0,
        HELD   = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [6:0]           r_cand;
    logic [7:0]           r_stab_cnt;
    logic                 r_dec_valid;
    logic [1:0]           r_dec_kind;
    logic [3:0]           r_dec_digit;
    logic [1:0]           r_dec_status;
    logic [NBITS_CNT-1:0] r_cnt_aprov;
    logic [NBITS_CNT-1:0] r_cnt_recup;
    logic [NBITS_CNT-1:0] r_cnt_reprov;
    logic                 r_err_invalid;

    logic                 w_change;
    logic                 w_accept;
    logic [1:0]           w_kind;
    logic [3:0]           w_digit;
    logic [1:0]           w_status;

    always_comb begin
        w_change    = (seg_in != r_cand);
        w_accept    = 1'b0;
        w_state_nxt = r_state;
        if (w_change) begin
            w_state_nxt = SETTLE;
        end else if (r_state == SETTLE && r_stab_cnt == c_ACCEPT_CNT) begin
            w_accept    = 1'b1;
            w_state_nxt = HELD;
        end
    end

    // On an accept edge seg_in equals r_cand, so decoding the candidate suffices.
    always_comb begin
        w_kind   = c_KIND_INVALID;
        w_digit  = 4'd0;
        w_status = c_ST_NONE;
        case (r_cand)
            7'h00: w_kind = c_KIND_BLANK;
            7'h3F: begin w_kind = c_KIND_DIGIT; w_digit = 4'd0; end
            7'h06: begin w_kind = c_KIND_DIGIT; w_digit = 4'd1; end
            7'h5B: begin w_kind = c_KIND_DIGIT; w_digit = 4'd2; end
            7'h4F: begin w_kind = c_KIND_DIGIT; w_digit = 4'd3; end
            7'h66: begin w_kind = c_KIND_DIGIT; w_digit = 4'd4; end
            7'h6D: begin w_kind = c_KIND_DIGIT; w_digit = 4'd5; end
            7'h7D: begin w_kind = c_KIND_DIGIT; w_digit = 4'd6; end
            7'h07: begin w_kind = c_KIND_DIGIT; w_digit = 4'd7; end
            7'h08: begin w_kind = c_KIND_STATUS; w_status = c_ST_APROV;  end
            7'h0E: begin w_kind = c_KIND_STATUS; w_status = c_ST_RECUP;  end
            7'h0C: begin w_kind = c_KIND_STATUS; w_status = c_ST_REPROV; end
            default: w_kind = c_KIND_INVALID;
        endcase
    end

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            r_state <= HELD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            r_cand        <= 7'h00;
            r_stab_cnt    <= 8'd0;
            r_dec_valid   <= 1'b0;
            r_dec_kind    <= c_KIND_BLANK;
            r_dec_digit   <= 4'd0;
            r_dec_status  <= c_ST_NONE;
            r_cnt_aprov   <= '0;
            r_cnt_recup   <= '0;
            r_cnt_reprov  <= '0;
            r_err_invalid <= 1'b0;
        end else begin
            r_dec_valid <= w_accept;
            if (w_change) begin
                r_cand     <= seg_in;
                r_stab_cnt <= 8'd0;
            end else if (r_state == SETTLE && !w_accept) begin
                r_stab_cnt <= r_stab_cnt + 8'd1;
            end
            if (w_accept) begin
                r_dec_kind   <= w_kind;
                r_dec_digit  <= w_digit;
                r_dec_status <= w_status;
                if (w_kind == c_KIND_INVALID) begin
                    r_err_invalid <= 1'b1;
                end
                if (w_status == c_ST_APROV && r_cnt_aprov != '1) begin
                    r_cnt_aprov <= r_cnt_aprov + 1'b1;
                end
                if (w_status == c_ST_RECUP && r_cnt_recup != '1) begin
                    r_cnt_recup <= r_cnt_recup + 1'b1;
                end
                if (w_status == c_ST_REPROV && r_cnt_reprov != '1) begin
                    r_cnt_reprov <= r_cnt_reprov + 1'b1;
                end
            end
        end
    end

`ifdef GRADE_CONSISTENCY_CHECK_EN
    logic [3:0] r_last_digit;
    logic       r_last_digit_vld;
    logic       r_mismatch;
    logic [1:0] w_exp_status;

    always_comb begin
        w_exp_status = c_ST_REPROV;
        if (r_last_digit >= 4'd7) begin
            w_exp_status = c_ST_APROV;
        end else if (r_last_digit >= 4'd4) begin
            w_exp_status = c_ST_RECUP;
        end
    end

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            r_last_digit     <= 4'd0;
            r_last_digit_vld <= 1'b0;
            r_mismatch       <= 1'b0;
        end else if (w_accept) begin
            if (w_kind == c_KIND_DIGIT) begin
                r_last_digit     <= w_digit;
                r_last_digit_vld <= 1'b1;
            end else if (w_kind == c_KIND_STATUS) begin
                r_last_digit_vld <= 1'b0;
                if (r_last_digit_vld && w_status != w_exp_status) begin
                    r_mismatch <= 1'b1;
                end
            end
        end
    end

    assign mismatch = r_mismatch;
`else
    assign mismatch = 1'b0;
`endif

    assign dec_valid   = r_dec_valid;
    assign dec_kind    = r_dec_kind;
    assign dec_digit   = r_dec_digit;
    assign dec_status  = r_dec_status;
    assign cnt_aprov   = r_cnt_aprov;
    assign cnt_recup   = r_cnt_recup;
    assign cnt_reprov  = r_cnt_reprov;
    assign err_invalid = r_err_invalid;

endmodule

`default_nettype wire
